// File: rtl/out_port_bcd_seg_pkg.sv
// Shared constants for the decimal display port: segment codes, converter states, helpers.
// Active-low segment codes, bit order g..a.
package out_port_bcd_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/out_port_bcd_seg_bin_to_bcd_iter.sv
// Sequential double-dabble converter: one input bit per cycle, BCD truncated to DIGITS digits.
module bin_to_bcd_iter
    import out_port_bcd_seg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     din,
    output logic                  busy,
    output logic                  last,
    output logic [4*DIGITS-1:0]   res_bcd,
    output logic                  res_ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]  adj;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        assign adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                          : bcd_q[4*k +: 4];
    end

    // res_* is the post-step value; on the last step the top captures it directly.
    assign res_bcd = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
    assign res_ovf = ovf_acc_q | adj[BCD_W-1];
    assign busy    = (state_q == ST_CONV);
    assign last    = busy && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        ovf_acc_d = ovf_acc_q;
        if (start) begin
            state_d   = ST_CONV;
            cnt_d     = '0;
            shift_d   = din;
            bcd_d     = '0;
            ovf_acc_d = 1'b0;
        end else if (busy) begin
            cnt_d     = cnt_q + CNT_W'(1);
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bcd_d     = res_bcd;
            ovf_acc_d = res_ovf;
            if (last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            ovf_acc_q <= ovf_acc_d;
        end
    end

endmodule

// File: rtl/out_port_bcd_seg.sv
// Decimal seven-segment output port with one-deep pending write slot.
// Optional leading-zero blanking via `SEG_LEAD_ZERO_BLANK_EN.
module out_port_bcd_seg
    import out_port_bcd_seg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     data_in,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;

    logic              conv_busy, conv_last, start;
    logic [DATA_W-1:0] start_data;
    logic [BCD_W-1:0]  res_bcd;
    logic              res_ovf;

    logic [BCD_W-1:0]  disp_q, disp_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;

    // A write on the completion edge beats the pending slot, which is then dropped.
    assign start      = wr_en ? (!conv_busy || conv_last) : (conv_last && pend_vld_q);
    assign start_data = wr_en ? data_in : pend_q;

    bin_to_bcd_iter #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .din     (start_data),
        .busy    (conv_busy),
        .last    (conv_last),
        .res_bcd (res_bcd),
        .res_ovf (res_ovf)
    );

    always_comb begin
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (conv_last) begin
            disp_d     = res_bcd;
            ovf_d      = res_ovf;
            done_d     = 1'b1;
            pend_vld_d = 1'b0;
        end else if (conv_busy && wr_en) begin
            pend_d     = data_in;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign busy = conv_busy;
    assign done = done_q;
    assign ovf  = ovf_q;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic lit;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        if (k == 0) begin : g_units
            assign lit = 1'b1;
        end else begin : g_upper
            assign lit = |disp_q[BCD_W-1:4*k];
        end
`else
        assign lit = 1'b1;
`endif
        assign seg_out[7*k +: 7] = lit ? seg_decode(disp_q[4*k +: 4]) : SEG_BLANK;
    end

endmodule
